mdu_seq: RTL

- Iterative RV32M multiply/divide unit; consumes the register-file read values (rv1/rv2) and the destination index, and produces a write-back value plus write enable for the register file.
- Handles all eight M-extension ops.
- Shift-add multiply and restoring divide, one bit per clock.
- Start/busy/done handshake; the core stalls while busy.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_div_step.sv | 23 ++
 rtl/mdu_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // RISC-V mandated results for divide-by-zero and signed overflow
  localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module mdu_div_step
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            bit_in,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] trial, diff;

  // rem_in < divisor, so trial < 2*divisor and the MSB of diff is a clean borrow
  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit, one bit per clock.
// Shift-add multiply and restoring divide on operand magnitudes; sign fix-up
// and RISC-V special cases are applied in FIN.
// Optional: MDU_EARLY_OUT_EN sends divide-by-zero, signed overflow and
// multiply-by-zero straight from IDLE to DONE.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wer
);

  mdu_state_e      state, state_nxt;
  mdu_op_e         op_r, op_in;
  logic [XLEN-1:0] hi, lo, opd, a_raw;
  logic            neg, div0, ovf;
  logic [CNT_W-1:0] cnt;

  logic            a_sgn, b_sgn, neg_in, div0_in, ovf_in, early_in;
  logic [XLEN-1:0] a_abs, b_abs, early_res;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] rem_nxt;
  logic            q_bit;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo_s, rem_s, fin_res;

  assign op_in = mdu_op_e'(op);

  // operand conditioning at accept: magnitudes, result sign, special cases
  always_comb begin
    a_sgn   = rs1_val[XLEN-1] && (op_in inside {MULH, MULHSU, DIV, REM});
    b_sgn   = rs2_val[XLEN-1] && (op_in inside {MULH, DIV, REM});
    a_abs   = a_sgn ? -rs1_val : rs1_val;
    b_abs   = b_sgn ? -rs2_val : rs2_val;
    neg_in  = (op_in == REM) ? a_sgn : (a_sgn ^ b_sgn);
    div0_in = op[2] && (rs2_val == '0);
    ovf_in  = (op_in inside {DIV, REM}) && (rs1_val == OVF_Q) && (rs2_val == '1);
    // REM/REMU have op[1] set; DIV/DIVU do not
    early_res = '0;
    if (div0_in)     early_res = op[1] ? rs1_val : DIV0_Q;
    else if (ovf_in) early_res = op[1] ? '0 : OVF_Q;
  end

`ifdef MDU_EARLY_OUT_EN
  assign early_in = div0_in || ovf_in || (!op[2] && (rs1_val == '0 || rs2_val == '0));
`else
  assign early_in = 1'b0;
`endif

  // multiply step: conditionally add multiplicand into the high half
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);

  mdu_div_step u_step (
    .rem_in  (hi),
    .divisor (opd),
    .bit_in  (lo[XLEN-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  // final sign correction and result selection
  always_comb begin
    prod  = {hi, lo};
    if (neg) prod = -prod;
    quo_s = neg ? -lo : lo;
    rem_s = neg ? -hi : hi;
    if (div0)          fin_res = op_r[1] ? a_raw : DIV0_Q;
    else if (ovf)      fin_res = op_r[1] ? '0 : OVF_Q;
    else if (!op_r[2]) fin_res = (op_r == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else               fin_res = op_r[1] ? rem_s : quo_s;
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = early_in ? DONE : RUN;
      RUN:     if (cnt == CNT_W'(XLEN-1)) state_nxt = FIN;
      FIN:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign wer  = done;

  // datapath: capture on accept, iterate in RUN, write result in FIN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_r <= MUL; hi <= '0; lo <= '0; opd <= '0; a_raw <= '0;
      neg <= 1'b0; div0 <= 1'b0; ovf <= 1'b0; cnt <= '0;
      result <= '0; rd_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r   <= op_in;
          a_raw  <= rs1_val;
          neg    <= neg_in;
          div0   <= div0_in;
          ovf    <= ovf_in;
          rd_out <= rd_in;
          cnt    <= '0;
          hi     <= '0;
          lo     <= op[2] ? a_abs : b_abs;  // dividend or multiplier
          opd    <= op[2] ? b_abs : a_abs;  // divisor or multiplicand
          if (early_in) result <= early_res;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_r[2]) begin
            hi <= rem_nxt;
            lo <= {lo[XLEN-2:0], q_bit};
          end else begin
            hi <= sum[XLEN:1];
            lo <= {sum[0], lo[XLEN-1:1]};
          end
        end
        FIN:     result <= fin_res;
        default: ;
      endcase
    end

endmodule
